weighted_masked_ranks: RTL and testbench

//  Streaming successor of the masked rank kernel for the weighted order-statistics (WOS) filter.

---
 rtl/weighted_masked_ranks_pkg.sv | 20 ++
 rtl/weighted_masked_ranks_if.sv | 31 +++
 rtl/weighted_masked_ranks_sum.sv | 31 +++
 rtl/weighted_masked_ranks.sv | 105 ++++++++++
 tb/tb_weighted_masked_ranks.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/weighted_masked_ranks_pkg.sv
// Shared helpers for the weighted order-statistics datapath: width derivations
// and the reset image of the rank matrix.
package wos_pkg;

  localparam int MAX_N = 64;

  function automatic int rank_width(input int n, input int w);
    return $clog2(n * ((1 << w) - 1) + 1);
  endfunction

  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Row j of the empty window: slot j ranks above every older slot.
  function automatic logic [MAX_N-1:0] ROW_RST(input int j);
    return (MAX_N'(1) << (j + 1)) - MAX_N'(1);
  endfunction

endpackage

// File: rtl/weighted_masked_ranks_if.sv
// Sample-in / ranks-out handshake bundle between the comparator bank and the
// WOS select stage.
interface weighted_masked_ranks_if
  import wos_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 4
);
  localparam int RANK_W = rank_width(N, W);
  localparam int FW     = fill_width(N);

  logic                in_valid;
  logic                in_ready;
  logic [N-2:0]        gts;
  logic [N-1:0]        mask;
  logic [N*W-1:0]      weights;
  logic                out_valid;
  logic                out_ready;
  logic [N*RANK_W-1:0] ranks_out;
  logic [FW-1:0]       fill_count;

  modport master (
    output in_valid, gts, mask, weights, out_ready,
    input  in_ready, out_valid, ranks_out, fill_count
  );

  modport slave (
    input  in_valid, gts, mask, weights, out_ready,
    output in_ready, out_valid, ranks_out, fill_count
  );
endinterface

// File: rtl/weighted_masked_ranks_sum.sv
// One slot's weighted rank: balanced adder tree over the weights of enabled
// samples ranking at or below it. Purely combinational.
module weighted_rank_sum
  import wos_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 4,
  localparam int RANK_W = rank_width(N, W)
) (
  input  logic [N-1:0]      row_i,
  input  logic [N-1:0]      eff_i,
  input  logic [N*W-1:0]    weights_i,
  input  logic              self_en_i,
  output logic [RANK_W-1:0] rank_o
);
  localparam int P = 1 << $clog2(N);

  logic [RANK_W-1:0] node [1:2*P-1];

  // Leaves at P..2P-1 (padded with zero), internal node i sums children 2i, 2i+1.
  always_comb begin
    for (int i = 1; i < 2 * P; i++) node[i] = '0;
    for (int k = 0; k < N; k++)
      node[P+k] = (row_i[k] & eff_i[k]) ? RANK_W'(weights_i[k*W +: W]) : '0;
    for (int i = P - 1; i >= 1; i--)
      node[i] = node[2*i] + node[2*i+1];
  end

  assign rank_o = self_en_i ? node[1] : '0;

endmodule

// File: rtl/weighted_masked_ranks.sv
// Sliding-window weighted rank kernel: NxN at-or-below matrix (stage A) feeding
// N per-slot rank adders registered into the output stage (stage B).
module weighted_masked_ranks
  import wos_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  weighted_masked_ranks_if.slave  bus
);
  localparam int RANK_W = rank_width(N, W);
  localparam int FW     = fill_width(N);

  logic [N-1:0][N-1:0]      row_q, row_d, row_init;
  logic [N-1:0]             mask_q, mask_d;
  logic [N*W-1:0]           w_q, w_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic                     a_valid_q, a_valid_d;
  logic                     out_valid_q, out_valid_d;
  logic [N-1:0][RANK_W-1:0] ranks_q, ranks_d, rank_c;
  logic                     clr, accept, b_en, in_ready;
  logic [N-1:0]             occ, eff;

  for (genvar j = 0; j < N; j++) begin : g_init
    localparam logic [MAX_N-1:0] RR = ROW_RST(j);
    assign row_init[j] = RR[N-1:0];
  end

  assign clr      = ~rst | flush;
  assign b_en     = a_valid_q & (~out_valid_q | bus.out_ready);
  assign in_ready = ~a_valid_q | b_en;
  assign accept   = bus.in_valid & in_ready & ~flush;

  // Newest sample enters at slot N-1; every older row shifts down one slot and
  // drops its column for the evicted sample.
  always_comb begin
    row_d       = row_q;
    mask_d      = mask_q;
    w_d         = w_q;
    fill_d      = fill_q;
    a_valid_d   = a_valid_q & ~b_en;
    out_valid_d = out_valid_q;
    ranks_d     = ranks_q;
    if (accept) begin
      row_d[N-1] = {1'b1, bus.gts};
      for (int i = 0; i < N - 1; i++)
        row_d[i] = {~bus.gts[i], row_q[i+1][N-1:1]};
      mask_d    = bus.mask;
      w_d       = bus.weights;
      a_valid_d = 1'b1;
      if (fill_q < FW'(N)) fill_d = fill_q + 1'b1;
    end
    if (b_en) begin
      ranks_d     = rank_c;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < N; k++) occ[k] = (k >= N - int'(fill_q));
  end
  assign eff = mask_q & occ;

  for (genvar j = 0; j < N; j++) begin : g_lane
    weighted_rank_sum #(.N(N), .W(W)) u_sum (
      .row_i     (row_q[j]),
      .eff_i     (eff),
      .weights_i (w_q),
      .self_en_i (eff[j]),
      .rank_o    (rank_c[j])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      row_q       <= row_init;
      mask_q      <= '0;
      w_q         <= '0;
      fill_q      <= '0;
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ranks_q     <= '0;
    end else begin
      row_q       <= row_d;
      mask_q      <= mask_d;
      w_q         <= w_d;
      fill_q      <= fill_d;
      a_valid_q   <= a_valid_d;
      out_valid_q <= out_valid_d;
      ranks_q     <= ranks_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.ranks_out  = ranks_q;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_weighted_masked_ranks.sv
// Directed vector bench for weighted_masked_ranks at N=4, W=2 (RANK_W=4).
module tb_weighted_masked_ranks;
  import wos_pkg::*;

  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  weighted_masked_ranks_if #(.N(N), .W(W)) bus ();

  weighted_masked_ranks #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [2:0]  gts;
    logic [3:0]  mask;
    logic [7:0]  w;
    logic [15:0] exp_r;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called and returns at a negedge; lat = posedges from accept edge to out_valid.
  task automatic push(input logic [2:0] g, input logic [3:0] m, input logic [7:0] w, output int lat);
    bus.in_valid = 1'b1;
    bus.gts      = g;
    bus.mask     = m;
    bus.weights  = w;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc;
    logic stable;
    logic [15:0] held;
    logic [15:0] outs [$];

    rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.gts = '0; bus.mask = '0; bus.weights = '0;
    bus.out_ready = 1'b1;
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_fill",      32'(bus.fill_count), 32'd0);
    chk("rst_ranks",     32'(bus.ranks_out), 32'd0);

    // single push; ascending 10..40 then 50 with s2 masked;
    // descending 40..10 then 25; all-zero mask; all-zero weights
    tbl[0]  = '{1'b1, 3'b000, 4'b1111, 8'h55, 16'h1000, 3'd1};
    tbl[1]  = '{1'b1, 3'b111, 4'b1111, 8'h67, 16'h1000, 3'd1};
    tbl[2]  = '{1'b0, 3'b111, 4'b1111, 8'h67, 16'h3200, 3'd2};
    tbl[3]  = '{1'b0, 3'b111, 4'b1111, 8'h67, 16'h4310, 3'd3};
    tbl[4]  = '{1'b0, 3'b111, 4'b1111, 8'h67, 16'h7643, 3'd4};
    tbl[5]  = '{1'b0, 3'b111, 4'b1011, 8'h67, 16'h5043, 3'd4};
    tbl[6]  = '{1'b1, 3'b000, 4'b1111, 8'h55, 16'h1000, 3'd1};
    tbl[7]  = '{1'b0, 3'b000, 4'b1111, 8'h55, 16'h1200, 3'd2};
    tbl[8]  = '{1'b0, 3'b000, 4'b1111, 8'h55, 16'h1230, 3'd3};
    tbl[9]  = '{1'b0, 3'b000, 4'b1111, 8'h55, 16'h1234, 3'd4};
    tbl[10] = '{1'b0, 3'b110, 4'b1111, 8'h55, 16'h3124, 3'd4};
    tbl[11] = '{1'b0, 3'b000, 4'b0000, 8'h55, 16'h0000, 3'd4};
    tbl[12] = '{1'b0, 3'b111, 4'b1111, 8'h00, 16'h0000, 3'd4};

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst_first) do_reset();
      push(tbl[i].gts, tbl[i].mask, tbl[i].w, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_ranks", i), 32'(bus.ranks_out), 32'(tbl[i].exp_r));
      chk($sformatf("vec%0d_fill", i), 32'(bus.fill_count), 32'(tbl[i].exp_fill));
    end

    // Backpressure: two accepts, then stall with output held.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.gts = 3'b111; bus.mask = 4'b1111; bus.weights = 8'h55;
    acc = 0; stable = 1'b1; held = '0;
    for (int c = 0; c < 5; c++) begin
      if (bus.in_valid && bus.in_ready) acc++;
      if (c == 2) held = bus.ranks_out;
      if (c > 2 && (bus.ranks_out !== held || !bus.out_valid)) stable = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_accepts",  32'(acc), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_held",     32'(held), 32'h1000);
    chk("bp_stable",   32'(stable), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid && bus.out_ready) outs.push_back(bus.ranks_out);
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_count", 32'(outs.size()), 32'd2);
    if (outs.size() == 2) begin
      chk("bp_out0", 32'(outs[0]), 32'h1000);
      chk("bp_out1", 32'(outs[1]), 32'h2100);
    end
    chk("bp_fill", 32'(bus.fill_count), 32'd2);

    // Flush together with a new sample, while an output is about to emerge.
    bus.in_valid = 1'b1; bus.gts = 3'b000; bus.mask = 4'b1111; bus.weights = 8'h55;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_fill",      32'(bus.fill_count), 32'd0);
    chk("fl_ranks",     32'(bus.ranks_out), 32'd0);
    chk("fl_in_ready",  32'(bus.in_ready), 32'd1);
    push(3'b000, 4'b1111, 8'h55, lat);
    chk("fl_push_lat",   32'(lat), 32'd2);
    chk("fl_push_ranks", 32'(bus.ranks_out), 32'h1000);
    chk("fl_push_fill",  32'(bus.fill_count), 32'd1);

    // Reset in the middle of backpressure.
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.gts = 3'b111;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("rb_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rb_fill",      32'(bus.fill_count), 32'd0);
    chk("rb_ranks",     32'(bus.ranks_out), 32'd0);
    chk("rb_in_ready",  32'(bus.in_ready), 32'd1);
    push(3'b000, 4'b1111, 8'h55, lat);
    chk("rb_push_lat",   32'(lat), 32'd2);
    chk("rb_push_ranks", 32'(bus.ranks_out), 32'h1000);
    chk("rb_push_fill",  32'(bus.fill_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
